// File: rtl/serial_add_sched_if.sv
// ---------------------------------------------------------------------------
// serial_add_sched_if
// Purpose : Bundles the two request channels, the result channel and the busy
//           status of the bit-serial addition scheduler.
// Signals : req0_* / req1_*  valid, ready, a, b, cin of requester 0 / 1
//           res_*            valid, ready, sum, cout, id of the result channel
//           busy             scheduler is in RUN or DONE
// Modports: master  requesters plus result consumer (testbench side)
//           slave   the scheduler itself
// ---------------------------------------------------------------------------
interface serial_add_sched_if #(
  parameter int WIDTH = 8
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req0_cin;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             req1_cin;

  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_sum;
  logic             res_cout;
  logic             res_id;

  logic             busy;

  modport master (
    output req0_valid, req0_a, req0_b, req0_cin,
    output req1_valid, req1_a, req1_b, req1_cin,
    output res_ready,
    input  req0_ready, req1_ready,
    input  res_valid, res_sum, res_cout, res_id, busy
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_cin,
    input  req1_valid, req1_a, req1_b, req1_cin,
    input  res_ready,
    output req0_ready, req1_ready,
    output res_valid, res_sum, res_cout, res_id, busy
  );
endinterface

// File: rtl/serial_add_sched.sv
// ---------------------------------------------------------------------------
// serial_add_sched
// Purpose : Shares one 1-bit full-adder slice between two requesters. An
//           accepted request is added LSB first over WIDTH cycles and the
//           result is returned tagged with the requester id.
// Ports   : clk  clock, rising edge
//           rst  asynchronous active-high reset
//           bus  serial_add_sched_if.slave (request/result channels, busy)
// ---------------------------------------------------------------------------

// Single-bit full adder: the only arithmetic resource of the scheduler.
module serial_add_fa (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_a ^ i_b ^ i_c;
  assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

module serial_add_sched #(
  parameter int WIDTH = 8
) (
  input logic             clk,
  input logic             rst,
  serial_add_sched_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_sum_sh;
  logic [WIDTH-1:0] w_sum_shift;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic             r_id;
  logic             r_last;
  logic             w_grant0;
  logic             w_grant1;
  logic             w_accept;
  logic             w_run_last;
  logic             w_fa_s;
  logic             w_fa_c;

  // Round-robin between two: a lone requester always wins, on a tie the one
  // that was not served last wins.
  assign w_grant0   = bus.req0_valid & (~bus.req1_valid | r_last);
  assign w_grant1   = bus.req1_valid & (~bus.req0_valid | ~r_last);
  assign w_run_last = (r_cnt == CNT_W'(WIDTH - 1));

  serial_add_fa u_fa (
    .i_a (r_a_sh[0]),
    .i_b (r_b_sh[0]),
    .i_c (r_carry),
    .o_s (w_fa_s),
    .o_c (w_fa_c)
  );

  // Sum bits enter at the MSB so that after WIDTH steps bit 0 sits at bit 0.
  always_comb begin
    w_sum_shift            = r_sum_sh >> 1;
    w_sum_shift[WIDTH-1]   = w_fa_s;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_accept       = 1'b0;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.res_valid  = 1'b0;
    case (r_state)
      S_IDLE: begin
        bus.req0_ready = w_grant0 & ~rst;
        bus.req1_ready = w_grant1 & ~rst;
        if (w_grant0 | w_grant1) begin
          w_accept     = 1'b1;
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (w_run_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        bus.res_valid = 1'b1;
        if (bus.res_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_sum_sh <= '0;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_id     <= 1'b0;
      r_last   <= 1'b1;  // requester 0 wins the first tie
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a_sh  <= w_grant1 ? bus.req1_a   : bus.req0_a;
            r_b_sh  <= w_grant1 ? bus.req1_b   : bus.req0_b;
            r_carry <= w_grant1 ? bus.req1_cin : bus.req0_cin;
            r_cnt   <= '0;
            r_id    <= w_grant1;
            r_last  <= w_grant1;
          end
        end
        S_RUN: begin
          r_a_sh   <= r_a_sh >> 1;
          r_b_sh   <= r_b_sh >> 1;
          r_sum_sh <= w_sum_shift;
          r_carry  <= w_fa_c;
          r_cnt    <= r_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Result fields are only presented while the result is valid.
  assign bus.res_sum  = (r_state == S_DONE) ? r_sum_sh : '0;
  assign bus.res_cout = (r_state == S_DONE) & r_carry;
  assign bus.res_id   = (r_state == S_DONE) & r_id;
  assign bus.busy     = (r_state != S_IDLE);
endmodule

// File: tb/tb_serial_add_sched.sv
// ---------------------------------------------------------------------------
// tb_serial_add_sched
// Purpose : Self-checking bench for serial_add_sched. Expected results are
//           pushed to a scoreboard queue at acceptance and compared while the
//           DUT presents them.
// ---------------------------------------------------------------------------
module tb_serial_add_sched;
  parameter int WIDTH = 8;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             id;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  exp_t sb_q[$];

  serial_add_sched_if #(.WIDTH(WIDTH)) bus ();

  serial_add_sched #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic cin, input logic id);
    exp_t           e;
    logic [WIDTH:0] full;
    full   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    e.sum  = full[WIDTH-1:0];
    e.cout = full[WIDTH];
    e.id   = id;
    return e;
  endfunction

  task automatic drive_req(input logic id, input logic v, input logic [WIDTH-1:0] a,
                           input logic [WIDTH-1:0] b, input logic cin);
    if (id) begin
      bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_cin = cin;
    end else begin
      bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_cin = cin;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_req(1'b0, 1'b1, '1, '1, 1'b1);
    drive_req(1'b1, 1'b1, '1, '1, 1'b1);
    bus.res_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: got r0=%b r1=%b, want 0 0", bus.req0_ready, bus.req1_ready);
    end
    checks++;
    if ({bus.res_valid, bus.busy, bus.res_cout, bus.res_id} !== 4'b0000 || bus.res_sum !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b busy=%b cout=%b id=%b sum=%h, want all 0",
               bus.res_valid, bus.busy, bus.res_cout, bus.res_id, bus.res_sum);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    drive_req(1'b0, 1'b0, '0, '0, 1'b0);
    drive_req(1'b1, 1'b0, '0, '0, 1'b0);
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.res_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got busy=%b valid=%b, want 0 0", bus.busy, bus.res_valid);
    end
    $display("reset: released");
  endtask

  task automatic test_single_op(input logic id, input logic [WIDTH-1:0] a,
                                input logic [WIDTH-1:0] b, input logic cin);
    exp_t e;
    int   lat;
    @(posedge clk); #1;
    bus.res_ready = 1'b1;
    drive_req(id, 1'b1, a, b, cin);
    @(negedge clk);
    checks++;
    if (id ? (bus.req1_ready !== 1'b1 || bus.req0_ready !== 1'b0)
           : (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0)) begin
      errors++;
      $display("FAIL single_grant id=%0d: got r0=%b r1=%b", id, bus.req0_ready, bus.req1_ready);
    end
    sb_q.push_back(model(a, b, cin, id));
    @(posedge clk); #1;
    // Operands become don't-care once accepted.
    drive_req(id, 1'b0, WIDTH'($urandom), WIDTH'($urandom), 1'b0);
    lat = 0;
    @(negedge clk);
    while (bus.res_valid !== 1'b1 && lat < WIDTH + 4) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== WIDTH) begin
      errors++;
      $display("FAIL single_latency id=%0d: got %0d cycles, want %0d", id, lat, WIDTH);
    end
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL single_result: scoreboard empty");
    end else begin
      e = sb_q.pop_front();
      if (bus.res_sum !== e.sum || bus.res_cout !== e.cout || bus.res_id !== e.id) begin
        errors++;
        $display("FAIL single_result: got sum=%h cout=%b id=%b, want sum=%h cout=%b id=%b",
                 bus.res_sum, bus.res_cout, bus.res_id, e.sum, e.cout, e.id);
      end
    end
    $display("op id=%0d a=%h b=%h cin=%0d -> sum=%h cout=%0d lat=%0d",
             id, a, b, cin, bus.res_sum, bus.res_cout, lat);
    @(negedge clk);
    checks++;
    if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL single_release: got valid=%b busy=%b, want 0 0", bus.res_valid, bus.busy);
    end
  endtask

  task automatic test_async_reset();
    logic stale;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;  // keeps small-WIDTH builds parked in DONE
    drive_req(1'b0, 1'b1, '1, WIDTH'(1), 1'b1);
    drive_req(1'b1, 1'b0, '0, '0, 1'b0);
    @(negedge clk);
    checks++;
    if (bus.req0_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_accept: got r0=%b, want 1", bus.req0_ready);
    end
    @(posedge clk); #1;
    drive_req(1'b0, 1'b0, '0, '0, 1'b0);
    repeat (3) @(posedge clk);
    #3;
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_busy_before: got busy=%b, want 1", bus.busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0 || bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL abort_immediate: got valid=%b busy=%b r0=%b r1=%b, want 0 0 0 0",
               bus.res_valid, bus.busy, bus.req0_ready, bus.req1_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    bus.res_ready = 1'b1;
    stale = 1'b0;
    repeat (WIDTH + 4) begin
      @(negedge clk);
      if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) stale = 1'b1;
    end
    checks++;
    if (stale) begin
      errors++;
      $display("FAIL abort_stale: got a result or busy after reset, want none");
    end
    @(posedge clk); #1;
    drive_req(1'b0, 1'b1, WIDTH'(3), WIDTH'(4), 1'b0);
    drive_req(1'b1, 1'b1, WIDTH'(5), WIDTH'(6), 1'b0);
    @(negedge clk);
    checks++;
    if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL abort_tie: got r0=%b r1=%b, want 1 0", bus.req0_ready, bus.req1_ready);
    end
    rst = 1'b1;  // withdraw before the edge so nothing is accepted
    #1;
    drive_req(1'b0, 1'b0, '0, '0, 1'b0);
    drive_req(1'b1, 1'b0, '0, '0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    $display("abort: reset mid-operation done");
  endtask

  // mode 0: both requesters always valid, res_ready=1
  // mode 1: both always valid, res_ready held low for 5 DONE cycles
  // mode 2: random valid gaps and random res_ready
  task automatic test_traffic(input string name, input int n_ops, input int mode);
    logic             pend[2];
    logic [WIDTH-1:0] oa[2];
    logic [WIDTH-1:0] ob[2];
    logic             oc[2];
    logic             m_last, g0, g1, gid;
    int               issued, done_cnt, cyc, m_state, m_cnt, m_done_cyc;
    exp_t             e;
    @(posedge clk); #1;
    rst = 1'b1;
    drive_req(1'b0, 1'b0, '0, '0, 1'b0);
    drive_req(1'b1, 1'b0, '0, '0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    pend[0] = 1'b0; pend[1] = 1'b0;
    m_last = 1'b1; m_state = 0; m_cnt = 0; m_done_cyc = 0;
    issued = 0; done_cnt = 0; cyc = 0;
    sb_q.delete();
    while (done_cnt < n_ops && cyc < n_ops * (WIDTH + 16) + 100) begin
      @(posedge clk); #1;
      for (int r = 0; r < 2; r++) begin
        if (!pend[r]) begin
          oa[r] = WIDTH'($urandom);
          ob[r] = WIDTH'($urandom);
          oc[r] = 1'($urandom);
          if (issued < n_ops && (mode != 2 || $urandom_range(0, 2) != 0)) begin
            pend[r] = 1'b1;
            issued++;
          end
        end
        drive_req(1'(r), pend[r], oa[r], ob[r], oc[r]);
      end
      case (mode)
        0:       bus.res_ready = 1'b1;
        1:       bus.res_ready = (m_state == 2 && m_done_cyc >= 5);
        default: bus.res_ready = ($urandom_range(0, 3) != 0);
      endcase
      @(negedge clk);
      g0 = pend[0] & (~pend[1] | m_last);
      g1 = pend[1] & (~pend[0] | ~m_last);
      checks++;
      if (bus.req0_ready !== (m_state == 0 && g0) || bus.req1_ready !== (m_state == 0 && g1)) begin
        errors++;
        $display("FAIL %s_ready cyc=%0d: got r0=%b r1=%b, want r0=%b r1=%b", name, cyc,
                 bus.req0_ready, bus.req1_ready, (m_state == 0 && g0), (m_state == 0 && g1));
      end
      checks++;
      if (bus.res_valid !== (m_state == 2) || bus.busy !== (m_state != 0)) begin
        errors++;
        $display("FAIL %s_status cyc=%0d: got valid=%b busy=%b, want valid=%b busy=%b", name, cyc,
                 bus.res_valid, bus.busy, (m_state == 2), (m_state != 0));
      end
      if (m_state == 2) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL %s_result cyc=%0d: scoreboard empty", name, cyc);
        end else if ({bus.res_sum, bus.res_cout, bus.res_id} !== sb_q[0]) begin
          errors++;
          $display("FAIL %s_result cyc=%0d: got sum=%h cout=%b id=%b, want sum=%h cout=%b id=%b",
                   name, cyc, bus.res_sum, bus.res_cout, bus.res_id, sb_q[0].sum, sb_q[0].cout, sb_q[0].id);
        end
        if (bus.res_ready && sb_q.size() > 0) begin
          e = sb_q.pop_front();
          done_cnt++;
          $display("%s: result %0d id=%0d sum=%h cout=%0d", name, done_cnt, e.id, e.sum, e.cout);
        end
      end
      case (m_state)
        0: begin
          if (g0 || g1) begin
            gid = g1;
            sb_q.push_back(model(oa[gid], ob[gid], oc[gid], gid));
            pend[gid] = 1'b0;
            m_last    = gid;
            m_state   = 1;
            m_cnt     = 0;
          end
        end
        1: begin
          if (m_cnt == WIDTH - 1) begin
            m_state    = 2;
            m_done_cyc = 0;
          end else begin
            m_cnt++;
          end
        end
        default: begin
          m_done_cyc++;
          if (bus.res_ready) m_state = 0;
        end
      endcase
      cyc++;
    end
    checks++;
    if (done_cnt != n_ops || issued != n_ops || sb_q.size() != 0) begin
      errors++;
      $display("FAIL %s_complete: got issued=%0d done=%0d left=%0d, want %0d %0d 0",
               name, issued, done_cnt, sb_q.size(), n_ops, n_ops);
    end
    @(posedge clk); #1;
    drive_req(1'b0, 1'b0, '0, '0, 1'b0);
    drive_req(1'b1, 1'b0, '0, '0, 1'b0);
    repeat (WIDTH + 8) @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    test_traffic("back_to_back", 6, 0);
  endtask

  task automatic test_backpressure();
    test_traffic("backpressure", 4, 1);
  endtask

  task automatic test_random();
    test_traffic("random", 1000, 2);
  endtask

  initial begin
    test_reset();
    test_single_op(1'b0, WIDTH'(8'h5A), WIDTH'(8'h3C), 1'b0);
    test_single_op(1'b1, '1, WIDTH'(1), 1'b1);
    test_single_op(1'b1, '1, '1, 1'b1);
    test_single_op(1'b0, '0, '0, 1'b0);
    test_async_reset();
    test_back_to_back();
    test_backpressure();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/serial_add_sched.md
# serial_add_sched

Bit-serial addition scheduler that shares a single 1-bit full-adder slice between two requesters. Each accepted request adds two WIDTH-bit operands plus a carry-in, LSB first, over WIDTH cycles. The result is returned with the requester's ID. The block sits between requesting units and the one full-adder resource, trading latency for area.

## Interface
- WIDTH, 8, operand/sum width in bits; legal range ≥1.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0_valid / req1_valid  in  1  requester 0/1 has an operation pending.
- req0_ready / req1_ready  out  1  request accepted this cycle when valid&ready.
- req0_a, req0_b / req1_a, req1_b  in  WIDTH  operands.
- req0_cin / req1_cin  in  1  carry-in.
- res_valid  out  1  result available.
- res_ready  in  1  consumer takes result when valid&ready.
- res_sum  out  WIDTH  (a+b+cin) mod 2^WIDTH.
- res_cout  out  1  carry out of bit WIDTH-1.
- res_id  out  1  requester that owns the result.
- busy  out  1  high in RUN or DONE.

## Operation
- One full-adder instance inside; the only arithmetic resource. Inputs are the current a bit, current b bit and the carry register. Outputs are the sum bit and next carry.
- States: IDLE, RUN, DONE.
- IDLE:
  - Grant is combinational from valids and the `last` pointer.
  - Only requester valid → it is granted.
  - Both valid → the one ≠ `last` is granted.
  - reqN_ready = (state==IDLE) & grantN & !rst; the other ready is 0.
  - On handshake: latch a, b into shift registers; carry ← cin; cnt ← 0; id ← N; last ← N; go to RUN.
- RUN, each cycle:
  - The slice adds a_sh[0], b_sh[0], carry.
  - Sum bit shifts into the MSB of sum_sh; a_sh, b_sh shift right; carry ← slice cout; cnt ← cnt+1.
  - When cnt==WIDTH-1 at the edge → DONE.
- DONE:
  - res_valid=1; res_sum=sum_sh; res_cout=carry; res_id=id; all outputs held stable.
  - res_ready=1 → IDLE at that edge; res_valid drops.
- Counter width is clog2(WIDTH+1); no wrap inside one operation.
- Requesters must hold valid and operands until accepted. After acceptance, operand inputs are don't-care.
- Nothing is accepted in RUN or DONE; both readies are 0. Pending requests wait, with no loss.
- Reset values: state IDLE, res_valid 0, res_sum 0, res_cout 0, res_id 0, busy 0, last 1 (so requester 0 wins the first tie), cnt 0, carry 0, req readies 0 while rst high.
- Reset in RUN/DONE aborts the operation. No result is produced and the pointer returns to 1.

## Timing
- Accept edge E0 → RUN for WIDTH cycles → res_valid high after edge E_WIDTH. Latency is WIDTH cycles from the accept edge to res_valid.
- DONE lasts ≥1 cycle. With res_ready held high, one operation completes every WIDTH+2 cycles: accept, WIDTH run cycles, one DONE cycle, one IDLE cycle.
- Earliest next accept is the cycle after the DONE→IDLE edge.
- res_ready is sampled only in DONE; it is ignored in other states.
- WIDTH=1: a single RUN cycle; latency 1.
- Request arriving in DONE while res_ready=1: not accepted that cycle, only in the next (IDLE).
- Both valid in every IDLE cycle: grants strictly alternate 0,1,0,1…

## Test plan
- WIDTH=8, req0 only, a=0x5A, b=0x3C, cin=0 → res_valid exactly 8 cycles after accept; res_sum=0x96, res_cout=0, res_id=0.
- req1 a=0xFF, b=0x01, cin=1 → res_sum=0x01, res_cout=1, res_id=1. Also a=0xFF, b=0xFF, cin=1 → 0xFF, cout=1.
- Both requesters valid continuously with res_ready=1 → accept order 0,1,0,1; exactly one ready per accept; ops spaced 10 cycles apart.
- Backpressure: hold res_ready=0 for 5 cycles in DONE → res_valid, res_sum, res_cout and res_id stable; both readies 0; busy=1. Release → IDLE next edge, then the pending request is accepted.
- Assert rst asynchronously mid-RUN (cnt=3) → res_valid=0 and busy=0 immediately; no stale result after release; the next tie is granted to requester 0.
- WIDTH=1 and WIDTH=16 builds, 1000 random ops with random valid/res_ready gaps → every result matches (a+b+cin) with the correct id; no request is dropped or duplicated.
